// File: rtl/cosecant_pkg.sv
// Shared constants for the cosecant engine: IEEE-754 double encodings, ROM geometry
// and the elaboration-time generator for the first-quadrant csc table.
package cosecant_pkg;

    localparam int          CSC_LUT_DEPTH = 91;
    localparam int          ADDR_W        = 7;
    localparam int          DP_W          = 64;
    localparam int          DP_SIGN_BIT   = 63;
    localparam logic [63:0] DP_POS_INF    = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] DP_QNAN       = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] DP_TWO        = 64'h4000_0000_0000_0000;
    localparam real         DEG2RAD       = 3.14159265358979323846 / 180.0;

    // csc(deg) as a double; only called with constant arguments to build the ROM.
    // 30 deg is pinned because sin(pi/6) in double lands one ulp low and 1/x rounds away from 2.0.
    function automatic logic [63:0] csc_word(input int deg);
        real s;
        if (deg <= 0 || deg >= CSC_LUT_DEPTH) return '0;
        if (deg == 30) return DP_TWO;
        s = $sin(deg * DEG2RAD);
        return $realtobits(1.0 / s);
    endfunction

endpackage

// File: rtl/cosecant_rom.sv
// First-quadrant cosecant ROM: rom[i] = csc(i deg) as IEEE-754 double, synchronous read.
module cosecant_rom
    import cosecant_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [DP_W-1:0]   dout
);

    // Entries past 90 deg read as zero so an out-of-range address is harmless.
    logic [DP_W-1:0] rom [0:(1 << ADDR_W) - 1];

    for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_rom
        assign rom[i] = csc_word(i);
    end

    always_ff @(posedge clk) begin
        if (rd_en) dout <= rom[addr];
    end

endmodule

// File: rtl/cosecant_unit.sv
// Pipelined double-precision cosecant: (quadrant, offset) -> fold to 0..90 deg -> ROM -> sign/pole/NaN.
// Latency 3 cycles after the sampling edge, one sample per cycle, no backpressure.
module cosecant_unit
    import cosecant_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LUT_DEPTH = CSC_LUT_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en_cosecant,
    input  logic [1:0]          quadrant,
    input  logic [DATA_W-1:0]   data_in,
    output logic [2*DATA_W-1:0] data_out,
    output logic                valid_out,
    output logic                div_zero,
    output logic                invalid
);

    localparam int MAX_DEG = LUT_DEPTH - 1;

    function automatic logic [DP_W-1:0] format_csc(input logic neg, input logic inv,
                                                   input logic pole, input logic [DP_W-1:0] word);
        if (inv)  return DP_QNAN;
        if (pole) return {neg, DP_POS_INF[DP_SIGN_BIT-1:0]};
        return {neg, word[DP_SIGN_BIT-1:0]};
    endfunction

    logic                  vld_p0, vld_p1, vld_p2;
    logic [1:0]            q_p0;
    logic [DATA_W-1:0]     din_p0;
    logic [ADDR_W-1:0]     idx_p1;
    logic                  neg_p1, inv_p1, pole_p1;
    logic                  neg_p2, inv_p2, pole_p2;
    logic [DP_W-1:0]       rom_word_p2;
    logic                  inv_s1, pole_s1;
    logic [ADDR_W-1:0]     idx_s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= en_cosecant;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- p0: input capture (held through bubbles so idle-cycle X never enters) ----
    always_ff @(posedge clk) begin
        if (en_cosecant) begin
            q_p0   <= quadrant;
            din_p0 <= data_in;
        end
    end

    // ---- S1: fold; the range test uses the full offset width, the fold only the low bits ----
    always_comb begin
        inv_s1 = din_p0 > DATA_W'(MAX_DEG);
        idx_s1 = '0;
        if (!inv_s1)
            idx_s1 = q_p0[0] ? ADDR_W'(MAX_DEG) - din_p0[ADDR_W-1:0] : din_p0[ADDR_W-1:0];
        pole_s1 = !inv_s1 && (idx_s1 == '0);
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            idx_p1  <= idx_s1;
            neg_p1  <= q_p0[1];
            inv_p1  <= inv_s1;
            pole_p1 <= pole_s1;
        end
    end

    // ---- S2: ROM read, flags ride alongside ----
    cosecant_rom u_rom (
        .clk   (clk),
        .addr  (idx_p1),
        .rd_en (vld_p1),
        .dout  (rom_word_p2)
    );

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            neg_p2  <= neg_p1;
            inv_p2  <= inv_p1;
            pole_p2 <= pole_p1;
        end
    end

    // ---- S3: format; outputs hold their last value across bubbles ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            div_zero  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            valid_out <= vld_p2;
            if (vld_p2) begin
                data_out <= format_csc(neg_p2, inv_p2, pole_p2, rom_word_p2);
                div_zero <= pole_p2;
                invalid  <= inv_p2;
            end
        end
    end

endmodule

// File: tb/tb_cosecant_unit.sv
// Scoreboard bench for cosecant_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_cosecant_unit;

    localparam int          DW   = 32;
    localparam real         PI   = 3.14159265358979323846;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF  = 64'h7FF0_0000_0000_0000;

    typedef struct {
        logic [63:0] data;
        bit          dz;
        bit          inv;
        bit          exact;
        int          issue;
        int          angle;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en_cosecant = 1'b0;
    logic [1:0]    quadrant = '0;
    logic [DW-1:0] data_in = '0;
    logic [63:0]   data_out;
    logic          valid_out, div_zero, invalid;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          run_len = 0;
    int          max_run = 0;
    logic [63:0] held_data = '0;
    logic        held_dz = 1'b0;
    logic        held_inv = 1'b0;

    cosecant_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_cosecant (en_cosecant),
        .quadrant    (quadrant),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .div_zero    (div_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t, want finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic bit within_ulp(input logic [63:0] a, input logic [63:0] b);
        longint d;
        if (a[63] !== b[63]) return 1'b0;
        d = longint'({1'b0, a[62:0]}) - longint'({1'b0, b[62:0]});
        return (d >= -1) && (d <= 1);
    endfunction

    // Reference: csc of the whole angle via the reference angle in 0..90, sign from quadrant alone.
    function automatic exp_t model(input logic [1:0] q, input logic [DW-1:0] d);
        exp_t e;
        int   ang, ra;
        real  mag;
        e.dz = 1'b0; e.inv = 1'b0; e.exact = 1'b1; e.issue = 0;
        if (d > 90) begin
            e.data = QNAN; e.inv = 1'b1; e.angle = -1;
            return e;
        end
        ang = 90 * int'(q) + int'(d);
        e.angle = ang;
        ra = ang % 180;
        if (ra > 90) ra = 180 - ra;
        if (ra == 0) begin
            e.data = INF; e.dz = 1'b1;
        end else begin
            mag = 1.0 / $sin(real'(ra) * (PI / 180.0));
            e.data = $realtobits(mag);
            e.exact = 1'b0;
        end
        e.data[63] = q[1];
        return e;
    endfunction

    always @(negedge reset_n) begin
        held_data = '0; held_dz = 1'b0; held_inv = 1'b0; run_len = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (valid_out) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got output %h, want no valid_out", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.exact) begin
                        check($sformatf("data a=%0d", e.angle), 66'(data_out), 66'(e.data));
                    end else begin
                        total++;
                        if (!within_ulp(data_out, e.data)) begin
                            bad++;
                            $display("FAIL data a=%0d: got %h want %h (+-1 ulp)", e.angle, data_out, e.data);
                        end
                    end
                    check($sformatf("div_zero a=%0d", e.angle), 66'(div_zero), 66'(e.dz));
                    check($sformatf("invalid a=%0d", e.angle), 66'(invalid), 66'(e.inv));
                    check($sformatf("latency a=%0d", e.angle), 66'(cyc - e.issue), 66'(3));
                end
                held_data = data_out; held_dz = div_zero; held_inv = invalid;
            end else begin
                run_len = 0;
                check("hold", {data_out, div_zero, invalid}, {held_data, held_dz, held_inv});
            end
        end
    end

    task automatic drive(input logic [1:0] q, input logic [DW-1:0] d);
        @(negedge clk);
        en_cosecant = 1'b1; quadrant = q; data_in = d;
    endtask

    task automatic send(input logic [1:0] q, input logic [DW-1:0] d);
        exp_t e;
        drive(q, d);
        e = model(q, d);
        e.issue = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_exact(input logic [1:0] q, input logic [DW-1:0] d,
                              input logic [63:0] data, input bit dz, input bit inv);
        exp_t e;
        drive(q, d);
        e.data = data; e.dz = dz; e.inv = inv; e.exact = 1'b1;
        e.issue = cyc + 1; e.angle = 90 * int'(q) + int'(d[7:0]);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        en_cosecant = 1'b0; quadrant = 2'($urandom); data_in = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outputs outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", 66'(data_out), 66'(0));
        check("reset valid_out", 66'(valid_out), 66'(0));
        check("reset div_zero", 66'(div_zero), 66'(0));
        check("reset invalid", 66'(invalid), 66'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Directed values with bit-exact expectations.
        send_exact(2'd0, 30, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        send_exact(2'd3, 0,  64'hBFF0_0000_0000_0000, 1'b0, 1'b0);
        send_exact(2'd2, 30, 64'hC000_0000_0000_0000, 1'b0, 1'b0);
        send_exact(2'd0, 0,  64'h7FF0_0000_0000_0000, 1'b1, 1'b0);
        send_exact(2'd2, 0,  64'hFFF0_0000_0000_0000, 1'b1, 1'b0);
        send_exact(2'd1, 90, 64'h7FF0_0000_0000_0000, 1'b1, 1'b0);
        send_exact(2'd0, 91, 64'h7FF8_0000_0000_0000, 1'b0, 1'b1);
        send_exact(2'd3, 32'hFFFF_FF00, 64'h7FF8_0000_0000_0000, 1'b0, 1'b1);
        send_exact(2'd0, 90, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
        idle();
        drain();

        // Full-circle stream, one angle per cycle.
        @(posedge clk);
        max_run = 0;
        for (int a = 0; a < 360; a++) send(2'(a / 90), DW'(a % 90));
        idle();
        drain();
        check("stream_run", 66'(max_run), 66'(360));

        // Random traffic with bubbles and occasional out-of-range offsets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 9) == 0) send(2'($urandom), $urandom);
                else send(2'($urandom), DW'($urandom_range(0, 90)));
            end else begin
                idle();
            end
        end
        idle();
        drain();

        // Async reset pulse with two samples in flight.
        send(2'd0, 45);
        send(2'd1, 10);
        @(posedge clk);
        #1 en_cosecant = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("flush data_out", 66'(data_out), 66'(0));
        check("flush valid_out", 66'(valid_out), 66'(0));
        check("flush div_zero", 66'(div_zero), 66'(0));
        check("flush invalid", 66'(invalid), 66'(0));
        exp_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        send(2'd2, 60);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
